// File: rtl/ahb_tohost_mailbox.sv
// AHB-Lite responder for the riscv-tests TOHOST/FROMHOST mailbox: decodes the
// test result, holds host requests until acknowledged, and runs a watchdog.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_RUN  | test running, no host request outstanding
//   ST_PEND | request in REQ_DATA waiting for REQ_ACK; TOHOST writes stall
//   ST_DONE | result final (absorbing until reset)
module ahb_tohost_mailbox #(
    parameter int unsigned TIMEOUT_CYC = 400000
) (
    input  logic        CLK,
    input  logic        RES_N,
    input  logic        S_HSEL,
    input  logic [1:0]  S_HTRANS,
    input  logic        S_HWRITE,
    input  logic [2:0]  S_HSIZE,
    input  logic [31:0] S_HADDR,
    input  logic [31:0] S_HWDATA,
    input  logic        S_HREADY,
    output logic        S_HREADYOUT,
    output logic [31:0] S_HRDATA,
    output logic        S_HRESP,
    output logic        TEST_DONE,
    output logic        TEST_PASS,
    output logic        TEST_TIMEOUT,
    output logic [30:0] TEST_CODE,
    output logic        REQ_VALID,
    output logic [31:0] REQ_DATA,
    input  logic        REQ_ACK,
    input  logic [31:0] ACK_DATA
);

    typedef enum logic [1:0] {ST_RUN, ST_PEND, ST_DONE} state_t;

    localparam logic        WD_EN   = (TIMEOUT_CYC != 0);
    localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYC - 1);

    state_t      state_q, state_d;
    logic        dp_valid_q, dp_valid_d;
    logic        dp_write_q, dp_write_d;
    logic        dp_err_q, dp_err_d;
    logic [1:0]  dp_addr_q, dp_addr_d;
    logic        err_phase_q, err_phase_d;
    logic [31:0] tohost_q, tohost_d;
    logic [31:0] fromhost_q, fromhost_d;
    logic [31:0] cycles_q, cycles_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        timeout_q, timeout_d;
    logic [30:0] code_q, code_d;
    logic        req_valid_q, req_valid_d;
    logic [31:0] req_data_q, req_data_d;

    logic addr_acc, stall, wr_done, wr_tohost, wd_fire;
    logic unused_addr;

    assign unused_addr = ^{S_HADDR[31:4], S_HADDR[1:0], S_HTRANS[0]};

    always_comb begin
        addr_acc  = S_HSEL & S_HTRANS[1] & S_HREADY;
        stall     = dp_valid_q & dp_write_q & ~dp_err_q & (dp_addr_q == 2'd0)
                    & (state_q == ST_PEND);
        wr_done   = dp_valid_q & dp_write_q & ~dp_err_q & ~stall;
        wr_tohost = wr_done & (dp_addr_q == 2'd0);
        wd_fire   = WD_EN & (cycles_q == WD_LAST) & (state_q != ST_DONE);

        // Error responses take two cycles; the first one holds the bus.
        S_HRESP = dp_valid_q & dp_err_q;
        if (dp_valid_q & dp_err_q) S_HREADYOUT = err_phase_q;
        else                       S_HREADYOUT = ~stall;

        S_HRDATA = 32'd0;
        if (dp_valid_q & ~dp_write_q & ~dp_err_q) begin
            case (dp_addr_q)
                2'd0:    S_HRDATA = tohost_q;
                2'd1:    S_HRDATA = fromhost_q;
                2'd2:    S_HRDATA = {28'd0, timeout_q, req_valid_q, pass_q, done_q};
                default: S_HRDATA = cycles_q;
            endcase
        end

        dp_valid_d = dp_valid_q;
        dp_write_d = dp_write_q;
        dp_err_d   = dp_err_q;
        dp_addr_d  = dp_addr_q;
        if (S_HREADY) begin
            dp_valid_d = addr_acc;
            dp_write_d = S_HWRITE;
            dp_addr_d  = S_HADDR[3:2];
            dp_err_d   = (S_HSIZE != 3'b010) | (S_HWRITE & S_HADDR[3]);
        end
        err_phase_d = dp_valid_q & dp_err_q & ~err_phase_q;

        tohost_d = wr_tohost ? S_HWDATA : tohost_q;
        fromhost_d = fromhost_q;
        if (wr_done & (dp_addr_q == 2'd1)) fromhost_d = S_HWDATA;
        if ((state_q == ST_PEND) & REQ_ACK) fromhost_d = ACK_DATA;

        cycles_d = cycles_q;
        if (~done_q & (cycles_q != 32'hFFFF_FFFF)) cycles_d = cycles_q + 32'd1;

        state_d     = state_q;
        done_d      = done_q;
        pass_d      = pass_q;
        timeout_d   = timeout_q;
        code_d      = code_q;
        req_valid_d = req_valid_q;
        req_data_d  = req_data_q;
        if (wd_fire) begin
            state_d     = ST_DONE;
            done_d      = 1'b1;
            pass_d      = 1'b0;
            timeout_d   = 1'b1;
            code_d      = 31'd0;
            req_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (wr_tohost & S_HWDATA[0]) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        pass_d  = (S_HWDATA == 32'd1);
                        code_d  = S_HWDATA[31:1];
                    end else if (wr_tohost & (S_HWDATA != 32'd0)) begin
                        state_d     = ST_PEND;
                        req_valid_d = 1'b1;
                        req_data_d  = S_HWDATA;
                    end
                end
                ST_PEND: begin
                    if (REQ_ACK) begin
                        state_d     = ST_RUN;
                        req_valid_d = 1'b0;
                    end
                end
                default: state_d = ST_DONE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            state_q     <= ST_RUN;
            dp_valid_q  <= 1'b0;
            dp_write_q  <= 1'b0;
            dp_err_q    <= 1'b0;
            dp_addr_q   <= 2'd0;
            err_phase_q <= 1'b0;
            tohost_q    <= 32'd0;
            fromhost_q  <= 32'd0;
            cycles_q    <= 32'd0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            code_q      <= 31'd0;
            req_valid_q <= 1'b0;
            req_data_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            dp_valid_q  <= dp_valid_d;
            dp_write_q  <= dp_write_d;
            dp_err_q    <= dp_err_d;
            dp_addr_q   <= dp_addr_d;
            err_phase_q <= err_phase_d;
            tohost_q    <= tohost_d;
            fromhost_q  <= fromhost_d;
            cycles_q    <= cycles_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
            code_q      <= code_d;
            req_valid_q <= req_valid_d;
            req_data_q  <= req_data_d;
        end
    end

    assign TEST_DONE    = done_q;
    assign TEST_PASS    = pass_q;
    assign TEST_TIMEOUT = timeout_q;
    assign TEST_CODE    = code_q;
    assign REQ_VALID    = req_valid_q;
    assign REQ_DATA     = req_data_q;

endmodule

// File: tb/tb_ahb_tohost_mailbox.sv
// Bench for ahb_tohost_mailbox: a driver queues each transfer, a negedge monitor
// checks the bus and result outputs against a reference model of the mailbox.
module tb_ahb_tohost_mailbox;

    localparam int TMO = 100;

    logic        CLK = 1'b0;
    logic        RES_N;
    logic        S_HSEL;
    logic [1:0]  S_HTRANS;
    logic        S_HWRITE;
    logic [2:0]  S_HSIZE;
    logic [31:0] S_HADDR;
    logic [31:0] S_HWDATA;
    logic        S_HREADY;
    logic        S_HREADYOUT;
    logic [31:0] S_HRDATA;
    logic        S_HRESP;
    logic        TEST_DONE;
    logic        TEST_PASS;
    logic        TEST_TIMEOUT;
    logic [30:0] TEST_CODE;
    logic        REQ_VALID;
    logic [31:0] REQ_DATA;
    logic        REQ_ACK;
    logic [31:0] ACK_DATA;

    always #5 CLK = ~CLK;
    assign S_HREADY = S_HREADYOUT;

    ahb_tohost_mailbox #(.TIMEOUT_CYC(TMO)) dut (
        .CLK(CLK), .RES_N(RES_N), .S_HSEL(S_HSEL), .S_HTRANS(S_HTRANS),
        .S_HWRITE(S_HWRITE), .S_HSIZE(S_HSIZE), .S_HADDR(S_HADDR),
        .S_HWDATA(S_HWDATA), .S_HREADY(S_HREADY), .S_HREADYOUT(S_HREADYOUT),
        .S_HRDATA(S_HRDATA), .S_HRESP(S_HRESP), .TEST_DONE(TEST_DONE),
        .TEST_PASS(TEST_PASS), .TEST_TIMEOUT(TEST_TIMEOUT), .TEST_CODE(TEST_CODE),
        .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA), .REQ_ACK(REQ_ACK),
        .ACK_DATA(ACK_DATA)
    );

    typedef struct {
        logic [1:0]  addr;
        bit          wr;
        logic [31:0] wdata;
        bit          err;
    } xfer_t;

    xfer_t sb_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model of the mailbox as seen after the most recent clock edge.
    bit          m_done, m_pass, m_tmo, m_req, m_err2;
    logic [30:0] m_code;
    logic [31:0] m_req_data, m_tohost, m_fromhost;
    int          k, m_done_edge;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return m_tohost;
            2'd1:    return m_fromhost;
            2'd2:    return {28'd0, m_tmo, m_req, m_pass, m_done};
            default: return m_done ? 32'(m_done_edge) : 32'(k);
        endcase
    endfunction

    always @(negedge CLK) begin
        xfer_t       t;
        bit          do_wr, wd, exp_rdy;
        logic [1:0]  wa;
        logic [31:0] wv;
        if (!RES_N) begin
            m_done = 0; m_pass = 0; m_tmo = 0; m_req = 0; m_err2 = 0;
            m_code = '0; m_req_data = '0; m_tohost = '0; m_fromhost = '0;
            k = 0; m_done_edge = 0;
            sb_q.delete();
        end else begin
            chk("test_done", TEST_DONE, m_done);
            chk("test_pass", TEST_PASS, m_pass);
            chk("test_timeout", TEST_TIMEOUT, m_tmo);
            chk("test_code", TEST_CODE, m_code);
            chk("req_valid", REQ_VALID, m_req);
            chk("req_data", REQ_DATA, m_req_data);
            do_wr = 0; wa = 0; wv = 0;
            if (sb_q.size() > 0) begin
                t = sb_q[0];
                if (t.err) begin
                    chk("err_ready", S_HREADYOUT, m_err2);
                    chk("err_resp", S_HRESP, 1);
                    chk("err_rdata", S_HRDATA, 0);
                    if (m_err2) begin
                        void'(sb_q.pop_front());
                        m_err2 = 0;
                    end else m_err2 = 1;
                end else begin
                    exp_rdy = !(t.wr && t.addr == 2'd0 && m_req);
                    chk("ready", S_HREADYOUT, exp_rdy);
                    chk("resp", S_HRESP, 0);
                    if (exp_rdy) begin
                        if (!t.wr) chk("rdata", S_HRDATA, model_read(t.addr));
                        else begin
                            chk("wr_rdata", S_HRDATA, 0);
                            do_wr = 1; wa = t.addr; wv = t.wdata;
                        end
                        void'(sb_q.pop_front());
                    end
                end
            end else begin
                chk("idle_ready", S_HREADYOUT, 1);
                chk("idle_resp", S_HRESP, 0);
                chk("idle_rdata", S_HRDATA, 0);
            end
            // Effects of the coming clock edge.
            wd = !m_done && (k == TMO - 1);
            if (do_wr && wa == 2'd0) m_tohost = wv;
            if (do_wr && wa == 2'd1) m_fromhost = wv;
            if (m_req && REQ_ACK) m_fromhost = ACK_DATA;
            if (wd) begin
                m_done = 1; m_pass = 0; m_tmo = 1; m_code = '0; m_req = 0;
                m_done_edge = k + 1;
            end else if (m_req) begin
                if (REQ_ACK) m_req = 0;
            end else if (!m_done && do_wr && wa == 2'd0) begin
                if (wv[0]) begin
                    m_done = 1; m_pass = (wv == 32'd1); m_code = wv[31:1];
                    m_done_edge = k + 1;
                end else if (wv != 0) begin
                    m_req = 1; m_req_data = wv;
                end
            end
            k++;
        end
    end

    task automatic bus_idle();
        S_HSEL = 0; S_HTRANS = 2'b00; S_HWRITE = 0; S_HSIZE = 3'b010;
        S_HADDR = $urandom();
    endtask

    task automatic xfer(input logic [1:0] a, input bit wr, input logic [2:0] sz,
                        input logic [31:0] wd, output int stalls);
        xfer_t t;
        bit    ok;
        S_HSEL = 1; S_HTRANS = 2'b10; S_HWRITE = wr; S_HSIZE = sz;
        S_HADDR = ($urandom() & 32'hFFFF_FFF3) | {28'd0, a, 2'b00};
        @(posedge CLK); #1;
        t.addr = a; t.wr = wr; t.wdata = wd;
        t.err = (sz != 3'b010) || (wr && a[1]);
        sb_q.push_back(t);
        bus_idle();
        S_HWDATA = wd;
        stalls = 0; ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (S_HREADYOUT) begin ok = 1; break; end
            stalls++;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL xfer_timeout: HREADYOUT stuck 0 for addr %0d", a);
        end
        @(posedge CLK); #1;
    endtask

    task automatic pulse_ack(input logic [31:0] d);
        REQ_ACK = 1; ACK_DATA = d;
        @(posedge CLK); #1;
        REQ_ACK = 0; ACK_DATA = $urandom();
    endtask

    task automatic do_reset();
        RES_N = 0; REQ_ACK = 0; ACK_DATA = 0; S_HWDATA = 0;
        bus_idle();
        repeat (2) @(posedge CLK);
        #1 RES_N = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          st;
        int          op;
        logic [31:0] v;
        logic [1:0]  a;
        logic [2:0]  sz;
        bit          wr;

        RES_N = 0;
        do_reset();
        chk("rst_ready", S_HREADYOUT, 1);
        chk("rst_done", TEST_DONE, 0);
        xfer(2'd0, 1, 3'b010, 32'd1, st);
        chk("pass_after_1", TEST_PASS, 1);
        chk("code_after_1", TEST_CODE, 0);
        xfer(2'd2, 0, 3'b010, 0, st);

        do_reset();
        xfer(2'd0, 1, 3'b010, 32'h7, st);
        chk("code_after_7", TEST_CODE, 3);
        xfer(2'd0, 1, 3'b010, 32'h1, st);
        chk("pass_sticky", TEST_PASS, 0);
        xfer(2'd2, 0, 3'b010, 0, st);

        do_reset();
        xfer(2'd0, 1, 3'b010, 32'h100, st);
        chk("req_valid_100", REQ_VALID, 1);
        chk("req_data_100", REQ_DATA, 32'h100);
        fork
            xfer(2'd0, 1, 3'b010, 32'h200, st);
            begin repeat (5) @(posedge CLK); #1; pulse_ack(32'h55); end
        join
        chk("stall_cycles", st, 5);
        xfer(2'd1, 0, 3'b010, 0, st);
        chk("req_data_200", REQ_DATA, 32'h200);
        pulse_ack(32'h66);
        xfer(2'd1, 0, 3'b010, 0, st);

        do_reset();
        xfer(2'd0, 1, 3'b000, 32'h1, st);
        xfer(2'd0, 0, 3'b010, 0, st);
        chk("byte_wr_no_done", TEST_DONE, 0);
        xfer(2'd2, 1, 3'b010, 32'hF, st);
        xfer(2'd3, 0, 3'b001, 0, st);
        xfer(2'd2, 0, 3'b010, 0, st);

        do_reset();
        repeat (105) @(posedge CLK);
        #1;
        chk("wd_timeout", TEST_TIMEOUT, 1);
        xfer(2'd3, 0, 3'b010, 0, st);
        xfer(2'd2, 0, 3'b010, 0, st);
        xfer(2'd3, 0, 3'b010, 0, st);

        do_reset();
        xfer(2'd0, 1, 3'b010, 32'h100, st);
        begin
            xfer_t t;
            S_HSEL = 1; S_HTRANS = 2'b10; S_HWRITE = 1; S_HSIZE = 3'b010; S_HADDR = 0;
            @(posedge CLK); #1;
            t.addr = 0; t.wr = 1; t.wdata = 32'h300; t.err = 0;
            sb_q.push_back(t);
            bus_idle();
            S_HWDATA = 32'h300;
        end
        repeat (2) @(posedge CLK);
        #1;
        chk("stall_before_rst", S_HREADYOUT, 0);
        RES_N = 0;
        #1;
        chk("rst_mid_ready", S_HREADYOUT, 1);
        chk("rst_mid_req", REQ_VALID, 0);
        chk("rst_mid_resp", S_HRESP, 0);
        chk("rst_mid_data", REQ_DATA, 0);
        do_reset();
        xfer(2'd0, 0, 3'b010, 0, st);
        xfer(2'd1, 0, 3'b010, 0, st);

        for (int it = 0; it < 25; it++) begin
            do_reset();
            for (int n = 0; n < 7; n++) begin
                op = $urandom_range(0, 5);
                case (op)
                    0, 1: begin
                        case ($urandom_range(0, 3))
                            0:       v = 32'd1;
                            1:       v = $urandom() | 32'd1;
                            2:       v = ($urandom() & ~32'd1) | 32'h10;
                            default: v = 32'd0;
                        endcase
                        if (m_req) begin
                            fork
                                xfer(2'd0, 1, 3'b010, v, st);
                                begin
                                    repeat ($urandom_range(1, 4)) @(posedge CLK);
                                    #1; pulse_ack($urandom());
                                end
                            join
                        end else xfer(2'd0, 1, 3'b010, v, st);
                    end
                    2: fork
                        xfer(2'd1, 1, 3'b010, $urandom(), st);
                        begin @(posedge CLK); #1; pulse_ack($urandom()); end
                    join
                    3: xfer(2'($urandom_range(0, 3)), 0, 3'b010, 0, st);
                    4: begin
                        a  = 2'($urandom_range(0, 3));
                        wr = 1'($urandom_range(0, 1));
                        sz = 3'($urandom_range(0, 2));
                        if (wr && a == 2'd0 && sz == 3'b010) sz = 3'b001;
                        xfer(a, wr, sz, $urandom(), st);
                    end
                    default: begin
                        repeat ($urandom_range(1, 5)) @(posedge CLK);
                        #1;
                        if ($urandom_range(0, 1) == 1) pulse_ack($urandom());
                    end
                endcase
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
